// File: rtl/sobel_edge_stage.sv
// 3x3 Sobel edge detector for the camera-to-VGA pixel path.
// Two line buffers, a 3x3 window, fixed 3-cycle latency, optional threshold.
module sobel_edge_stage #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pix,
  input  logic       thresh_en,
  input  logic [7:0] thresh,
  output logic       out_valid,
  output logic [7:0] out_pix,
  output logic       out_sof
);

  localparam int CW = (WIDTH  > 2) ? $clog2(WIDTH)  : 2;
  localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 2;

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  logic          acc;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] pos_c;
  logic [RW-1:0] pos_r;
  logic [CW-1:0] nxt_c;
  logic [RW-1:0] nxt_r;
  logic          border;

  // Pixels presented during reset are dropped entirely.
  assign acc = in_valid & ~RESET;

  always_comb begin
    pos_c = in_sof ? '0 : col;
    pos_r = in_sof ? '0 : row;
    nxt_c = pos_c + CW'(1);
    nxt_r = pos_r;
    if (pos_c == COL_MAX) begin
      nxt_c = '0;
      nxt_r = (pos_r == ROW_MAX) ? '0 : pos_r + RW'(1);
    end
  end

  assign border = (pos_c < COL_TWO) | (pos_r < ROW_TWO);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      col <= nxt_c;
      row <= nxt_r;
    end
  end

  // Line buffers hold rows r-1 (lb0) and r-2 (lb1); never cleared.
  logic [7:0] lb0 [WIDTH];
  logic [7:0] lb1 [WIDTH];
  logic [7:0] lb_top;
  logic [7:0] lb_mid;

  assign lb_top = lb1[pos_c];
  assign lb_mid = lb0[pos_c];

  always_ff @(posedge CLOCK_50) begin
    if (acc) begin
      lb1[pos_c] <= lb0[pos_c];
      lb0[pos_c] <= in_pix;
    end
  end

  // Stage 1: window shift plus sideband.
  logic [7:0] win [3][3];
  logic       s1_valid;
  logic       s1_sof;
  logic       s1_border;
  logic       s1_te;
  logic [7:0] s1_th;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_border <= 1'b0;
      s1_te     <= 1'b0;
      s1_th     <= '0;
    end else begin
      s1_valid <= acc;
      s1_sof   <= acc & in_sof;
      if (acc) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb_top;
        win[1][2] <= lb_mid;
        win[2][2] <= in_pix;
        s1_border <= border;
        s1_te     <= thresh_en;
        s1_th     <= thresh;
      end
    end
  end

  // Stage 2: gradients and magnitude.
  logic [11:0]        gx_p;
  logic [11:0]        gx_n;
  logic [11:0]        gy_p;
  logic [11:0]        gy_n;
  logic signed [11:0] gx;
  logic signed [11:0] gy;
  logic [11:0]        ax;
  logic [11:0]        ay;
  logic [11:0]        mag;

  always_comb begin
    gx_p = {4'b0, win[0][2]} + {3'b0, win[1][2], 1'b0}
         + {4'b0, win[2][2]};
    gx_n = {4'b0, win[0][0]} + {3'b0, win[1][0], 1'b0}
         + {4'b0, win[2][0]};
    gy_p = {4'b0, win[2][0]} + {3'b0, win[2][1], 1'b0}
         + {4'b0, win[2][2]};
    gy_n = {4'b0, win[0][0]} + {3'b0, win[0][1], 1'b0}
         + {4'b0, win[0][2]};
    gx   = $signed(gx_p) - $signed(gx_n);
    gy   = $signed(gy_p) - $signed(gy_n);
    ax   = gx[11] ? 12'(-gx) : 12'(gx);
    ay   = gy[11] ? 12'(-gy) : 12'(gy);
    mag  = ax + ay;
  end

  logic        s2_valid;
  logic        s2_sof;
  logic        s2_border;
  logic        s2_te;
  logic [7:0]  s2_th;
  logic [11:0] s2_mag;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s2_valid  <= 1'b0;
      s2_sof    <= 1'b0;
      s2_border <= 1'b0;
      s2_te     <= 1'b0;
      s2_th     <= '0;
      s2_mag    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      if (s1_valid) begin
        s2_border <= s1_border;
        s2_te     <= s1_te;
        s2_th     <= s1_th;
        s2_mag    <= mag;
      end
    end
  end

  // Stage 3: saturate, threshold, border mask.
  logic [7:0] sat;
  logic [7:0] res;

  always_comb begin
    sat = (s2_mag > 12'd255) ? 8'hFF : s2_mag[7:0];
    res = sat;
    if (s2_te) begin
      res = (sat >= s2_th) ? 8'hFF : 8'h00;
    end
    if (s2_border) begin
      res = 8'h00;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_pix   <= '0;
    end else begin
      out_valid <= s2_valid;
      out_sof   <= s2_sof;
      if (s2_valid) begin
        out_pix <= res;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_stage.sv
// Bench for sobel_edge_stage on a small frame.
// Reference keeps the whole image and applies Sobel on it directly.
module tb_sobel_edge_stage;

  localparam int W = 16;
  localparam int H = 8;

  logic       CLOCK_50 = 1'b0;
  logic       RESET = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pix = '0;
  logic       thresh_en = 1'b0;
  logic [7:0] thresh = '0;
  logic       out_valid;
  logic [7:0] out_pix;
  logic       out_sof;

  sobel_edge_stage #(.WIDTH(W), .HEIGHT(H)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_pix   (in_pix),
    .thresh_en(thresh_en),
    .thresh   (thresh),
    .out_valid(out_valid),
    .out_pix  (out_pix),
    .out_sof  (out_sof)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         edge_n;
    logic [7:0] pix;
    logic       sof;
  } exp_t;

  exp_t q[$];
  int   img [H][W];
  int   mr = 0;
  int   mc = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_sof = 0;
  int   n_40 = 0;
  int   n_255 = 0;
  logic [7:0] last_pix = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sobel_ref(int r, int c, bit te, int th);
    int gx, gy, m, s;
    if (r < 2 || c < 2) return 0;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    s = (m > 255) ? 255 : m;
    if (te) return (s >= th) ? 255 : 0;
    return s;
  endfunction

  function automatic int gen(int mode, int r, int c);
    case (mode)
      0: return 100;
      1: return (c < W/2) ? 0 : 200;
      2: return (r < H/2) ? 0 : 10;
      default: return int'($urandom_range(255));
    endcase
  endfunction

  task automatic step(input logic v, input logic sof,
                      input logic [7:0] pix, input logic te,
                      input logic [7:0] th, input logic rst);
    exp_t e;
    int   pr, pc;
    in_valid  = v;
    in_sof    = sof;
    in_pix    = pix;
    thresh_en = te;
    thresh    = th;
    RESET     = rst;
    if (rst) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      pr = sof ? 0 : mr;
      pc = sof ? 0 : mc;
      img[pr][pc] = int'(pix);
      e.pix    = 8'(sobel_ref(pr, pc, te, int'(th)));
      e.sof    = sof;
      e.edge_n = cyc + 1;
      q.push_back(e);
      mc = pc + 1;
      mr = pr;
      if (mc == W) begin
        mc = 0;
        mr = (pr == H - 1) ? 0 : pr + 1;
      end
    end
    @(posedge CLOCK_50);
    cyc++;
    #1;
    if (rst) begin
      q.delete();
      last_pix = '0;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_sof", 32'(out_sof), 0);
      chk("rst_pix", 32'(out_pix), 0);
    end else if (out_valid) begin
      n_valid++;
      if (out_sof) n_sof++;
      if (out_pix == 8'd40) n_40++;
      if (out_pix == 8'd255) n_255++;
      chk("spurious", 32'(q.size() == 0), 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        // Three cycles from acceptance edge: visible after edge +2.
        chk("latency", 32'(cyc), 32'(e.edge_n + 2));
        chk("pix", 32'(out_pix), 32'(e.pix));
        chk("sof", 32'(out_sof), 32'(e.sof));
        last_pix = e.pix;
      end
    end else begin
      chk("missing", 32'(q.size() != 0 && q[0].edge_n + 2 <= cyc), 0);
      if (q.size() != 0 && q[0].edge_n + 2 <= cyc) void'(q.pop_front());
      chk("hold", 32'(out_pix), 32'(last_pix));
      chk("sof_idle", 32'(out_sof), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic stream(input int mode, input logic te, input logic [7:0] th,
                        input int duty, input logic sof_first,
                        input int npix);
    logic       t;
    logic [7:0] h;
    for (int i = 0; i < npix; i++) begin
      while (int'($urandom_range(99)) >= duty) idle(1);
      t = te;
      h = th;
      if (mode == 4) begin
        t = 1'($urandom_range(1));
        h = 8'($urandom_range(255));
      end
      step(1'b1, sof_first && i == 0,
           8'(gen(mode, (sof_first && i == 0) ? 0 : mr,
                        (sof_first && i == 0) ? 0 : mc)),
           t, h, 1'b0);
    end
  endtask

  task automatic clr_counts();
    n_valid = 0;
    n_sof = 0;
    n_40 = 0;
    n_255 = 0;
  endtask

  initial begin
    step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    step(1'b1, 1'b1, 8'd77, 1'b0, 8'd0, 1'b1);
    idle(3);

    clr_counts();
    stream(0, 1'b0, 8'd0, 100, 1'b1, W*H);
    idle(5);
    chk("uni_count", 32'(n_valid), 32'(W*H));
    chk("uni_sof", 32'(n_sof), 1);
    chk("uni_drain", 32'(q.size()), 0);

    clr_counts();
    stream(1, 1'b0, 8'd0, 100, 1'b1, W*H);
    idle(5);
    chk("vstep_255", 32'(n_255), 32'(2*(H-2)));

    clr_counts();
    stream(2, 1'b0, 8'd0, 100, 1'b1, W*H);
    idle(5);
    chk("hstep_40", 32'(n_40), 32'(2*(W-2)));

    clr_counts();
    stream(2, 1'b1, 8'd40, 100, 1'b1, W*H);
    idle(5);
    chk("hstep_th40", 32'(n_255), 32'(2*(W-2)));

    clr_counts();
    stream(2, 1'b1, 8'd41, 100, 1'b1, W*H);
    idle(5);
    chk("hstep_th41", 32'(n_255), 0);

    clr_counts();
    stream(3, 1'b0, 8'd0, 50, 1'b1, W*H);
    stream(4, 1'b0, 8'd0, 50, 1'b0, W*H);
    idle(5);
    chk("rand_count", 32'(n_valid), 32'(2*W*H));
    chk("rand_drain", 32'(q.size()), 0);

    stream(3, 1'b0, 8'd0, 60, 1'b1, 5*W + 10);
    step(1'b1, 1'b0, 8'd9, 1'b0, 8'd0, 1'b1);
    idle(6);
    clr_counts();
    stream(4, 1'b0, 8'd0, 70, 1'b1, W*H);
    idle(5);
    chk("rst_recover", 32'(n_valid), 32'(W*H));

    stream(3, 1'b0, 8'd0, 80, 1'b1, 10*0 + 3*W + 7);
    stream(3, 1'b0, 8'd0, 80, 1'b1, W*H);
    idle(5);
    chk("resync_drain", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_edge_stage.md
# sobel_edge_stage

Streaming 3x3 Sobel edge detector that sits between the RGB processing stage and the cursor overlay stage in the camera-to-VGA pixel path. It consumes one 8-bit greyscale pixel per valid cycle in raster order, keeps two line buffers and a 3x3 window, and emits one edge pixel per input pixel at a fixed latency. The edge pixel is either the saturated gradient magnitude or a binary thresholded value. Its output drives the R, G and B inputs of the overlay stage identically.

## Interface
- WIDTH, 640, active pixels per line; sets line-buffer depth and column wrap.
- HEIGHT, 480, active lines per frame; sets row wrap.
- CLOCK_50  in  1  sole clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel strobe; the block processes a pixel only in cycles where this is high.
- in_sof  in  1  start of frame; qualified by in_valid; marks the pixel at col 0, row 0.
- in_pix  in  8  greyscale pixel.
- thresh_en  in  1  1 = binary output, 0 = magnitude output; sampled with the pixel.
- thresh  in  8  binary threshold; sampled with the pixel.
- out_valid  out  1  edge pixel strobe.
- out_pix  out  8  edge pixel.
- out_sof  out  1  high with the out_valid that belongs to the input in_sof pixel.

## Operation
- **Position counters.**
  - col (0..WIDTH-1) and row (0..HEIGHT-1) give the position of the current accepted pixel.
  - After each accepted pixel, col increments. At WIDTH-1, col wraps to 0 and row increments.
  - At HEIGHT-1 and col WIDTH-1, row wraps to 0.
  - in_valid & in_sof forces the current pixel's position to (0,0), regardless of the counters. The following pixel is (1,0).
  - in_sof with in_valid low is ignored.
- **Line buffers.** lb0 and lb1 are each WIDTH x 8.
  - On every accepted pixel at column c: lb1[c] <= old lb0[c], and lb0[c] <= in_pix.
  - Result: lb0 holds row r-1 and lb1 holds row r-2.
  - Contents are not cleared by reset.
- **Window.**
  - Each accepted pixel shifts a new column {lb1[c], lb0[c], in_pix} (top, mid, bottom) into a 3-column window.
  - Column 2 is the newest pixel, c. Column 0 is c-2. The window centre is (c-1, r-1).
- **Arithmetic.** p[row][col] is the window pixel; all values are unsigned 8-bit.
  - Gx = (p00 + 2p10 + p20) subtracted from (p02 + 2p12 + p22); signed 11-bit.
  - Gy = (p00 + 2p01 + p02) subtracted from (p20 + 2p21 + p22); signed 11-bit.
  - mag = |Gx| + |Gy|; unsigned 12-bit, maximum 2040.
  - sat = 255 if mag > 255, else mag[7:0].
  - out_pix = thresh_en ? (sat >= thresh ? 255 : 0) : sat.
  - thresh_en and thresh are pipelined alongside the pixel that sampled them.
- **Border rule.** If c < 2 or r < 2 for the input pixel, out_pix = 0 in both modes.
  - The output image is therefore shifted by one pixel right and one pixel down.
  - The first two rows and the first two columns are black.
- **No backpressure.** Pipeline registers advance only on accepted pixels or carry a valid bit; gaps in in_valid never drop or duplicate pixels.

## Timing
- Fixed latency of 3 cycles: in_valid high in cycle T gives out_valid high in cycle T+3 with that pixel's result.
- out_valid is a 3-deep delayed copy of in_valid. out_sof is likewise a delayed copy of in_valid & in_sof.
- Back-to-back valid input gives back-to-back valid output. Gaps are preserved exactly.
- out_pix holds its last value while out_valid is low.
- **Reset values:**
  - out_valid = 0, out_pix = 0, out_sof = 0.
  - col = 0, row = 0.
  - Window registers and pipeline registers = 0.
- **Reset timing:**
  - RESET high in cycle T: outputs are 0 from T+1. Pixels in flight are discarded; no out_valid for them.
  - in_valid during a reset cycle is ignored.
  - The first pixel after reset is at (0,0), whether or not in_sof is asserted with it.
- **Simultaneous events:**
  - in_sof mid-line: counters restart at (0,0) immediately. Border masking covers the stale line-buffer data.
  - Row wrap without in_sof: same as a restart at row 0.

## Test plan
- **Uniform field.** Stream a 640x480 frame of all 100 with thresh_en=0 -> 307200 out_valid pulses, every out_pix = 0, exactly one out_sof.
- **Vertical step.** Pixels 0 for col < 320 and 200 for col ≥ 320, thresh_en=0 -> for input rows ≥ 2, out_pix = 255 at input cols 320 and 321, and 0 everywhere else.
- **Horizontal step.** Pixels 0 for row < 240 and 10 for row ≥ 240:
  - thresh_en=0 -> out_pix = 40 at input rows 240 and 241 (cols ≥ 2), else 0.
  - thresh_en=1, thresh=40 -> those pixels = 255.
  - thresh_en=1, thresh=41 -> all 0.
- **Latency and gaps.** Random in_valid duty of ~50% -> each out_valid occurs exactly 3 cycles after its in_valid, pulse counts match, and values match a golden model.
- **Reset mid-frame.** Assert RESET for 1 cycle at (100,50) -> out_valid = 0 from the next cycle, with no late outputs. After restarting with in_sof, the first two output rows are 0 and row 2 onward match the golden model.
- **Resync.** Assert in_sof at col 300 of row 10 -> counters restart there, and outputs for new rows 0–1 and cols 0–1 are 0.
